// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller.
// Stall vector bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
// A stage's bit set means "hold this register"; every register upstream of
// the requesting stage is held as well.
package pipe_stall_ctrl_pkg;

  localparam logic       RstEnable    = 1'b0;
  localparam logic       StallEnable  = 1'b1;
  localparam logic       StallDisable = 1'b0;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_mc_counter.sv
// Multi-cycle EX residence counter.
// Loads len-2 when a multi-cycle op arrives in IDLE. In BUSY it counts down
// to zero; the cycle at zero is the final EX cycle. A MEM stall freezes it,
// and a flush returns it to IDLE.
// Ports:
//   clk, rst (async, active low), flush, freeze (MEM stall)
//   req, len     : incoming multi-cycle request and total EX residence
//   busy         : in BUSY state
//   ex_hold      : EX must be held this cycle
//   elapsed      : EX cycles already spent on the current op
//   done         : final EX cycle, result valid (combinational)
module pipe_stall_ctrl_mc_counter
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                freeze,
  input  logic                req,
  input  logic [MC_LEN_W-1:0] len,
  output logic                busy,
  output logic                ex_hold,
  output logic [MC_LEN_W-1:0] elapsed,
  output logic                done
);

  localparam logic [MC_LEN_W-1:0] LEN_TWO = MC_LEN_W'(2);

  mc_state_e           state;
  logic [MC_LEN_W-1:0] cnt;
  logic                long_op;
  logic                cnt_zero;

  // Len 0 and 1 complete in a single EX cycle without entering BUSY.
  assign long_op  = (len >= LEN_TWO);
  assign cnt_zero = (cnt == '0);
  assign busy     = (state == MC_BUSY);
  assign ex_hold  = (!busy && req && long_op) || (busy && !cnt_zero);
  assign done     = !flush && ((!busy && req && !long_op) ||
                               (busy && cnt_zero && !freeze));

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state   <= MC_IDLE;
      cnt     <= '0;
      elapsed <= '0;
    end else if (flush) begin
      state   <= MC_IDLE;
      cnt     <= '0;
      elapsed <= '0;
    end else begin
      unique case (state)
        MC_IDLE: begin
          if (req && long_op) begin
            state   <= MC_BUSY;
            cnt     <= len - LEN_TWO;
            elapsed <= MC_LEN_W'(1);
          end
        end
        MC_BUSY: begin
          // Requests arriving while BUSY belong to the held instruction.
          if (!freeze) begin
            if (!cnt_zero) begin
              cnt     <= cnt - 1'b1;
              elapsed <= elapsed + 1'b1;
            end else begin
              state   <= MC_IDLE;
              elapsed <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline sequencer: merges stall requests into the stall vector,
// drives the flush, and holds multi-cycle ops in EX.
// Priority: flush > MEM wait > EX multi-cycle hold > ID hazard.
// Optional macro STALL_STATS_EN adds saturating stall-cycle counters
// (stat_id, stat_ex, stat_mem) counting cycles each source wins.
// Ports:
//   clk, rst (async, active low)
//   stallreq_id, stallreq_mem, flush     : stall/flush requests
//   ex_mc_req, ex_mc_len                 : multi-cycle op in EX and its length
//   stall[5:0], flush_o                  : to pipeline registers
//   mc_busy, mc_cyc, mc_done             : multi-cycle status
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6
`ifdef STALL_STATS_EN
  , parameter int STAT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id,
  input  logic                stallreq_mem,
  input  logic                flush,
  input  logic                ex_mc_req,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  output logic [5:0]          stall,
  output logic                flush_o,
  output logic                mc_busy,
  output logic [MC_LEN_W-1:0] mc_cyc,
  output logic                mc_done
`ifdef STALL_STATS_EN
  , output logic [STAT_W-1:0] stat_id
  , output logic [STAT_W-1:0] stat_ex
  , output logic [STAT_W-1:0] stat_mem
`endif
);

  logic ex_hold;
  logic done_raw;

  pipe_stall_ctrl_mc_counter #(.MC_LEN_W(MC_LEN_W)) u_mc (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .freeze  (stallreq_mem),
    .req     (ex_mc_req),
    .len     (ex_mc_len),
    .busy    (mc_busy),
    .ex_hold (ex_hold),
    .elapsed (mc_cyc),
    .done    (done_raw)
  );

  // Combinational outputs are forced quiet while reset is held.
  assign mc_done = (rst != RstEnable) && done_raw;

  always_comb begin
    stall   = STALL_NONE;
    flush_o = StallDisable;
    if (rst != RstEnable) begin
      if (flush)             flush_o = StallEnable;
      else if (stallreq_mem) stall   = STALL_MEM;
      else if (ex_hold)      stall   = STALL_EX;
      else if (stallreq_id)  stall   = STALL_ID;
    end
  end

`ifdef STALL_STATS_EN
  logic win_mem, win_ex, win_id;

  assign win_mem = (rst != RstEnable) && !flush && stallreq_mem;
  assign win_ex  = (rst != RstEnable) && !flush && !stallreq_mem && ex_hold;
  assign win_id  = (rst != RstEnable) && !flush && !stallreq_mem && !ex_hold
                   && stallreq_id;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      stat_id  <= '0;
      stat_ex  <= '0;
      stat_mem <= '0;
    end else begin
      if (win_id  && stat_id  != '1) stat_id  <= stat_id  + 1'b1;
      if (win_ex  && stat_ex  != '1) stat_ex  <= stat_ex  + 1'b1;
      if (win_mem && stat_mem != '1) stat_mem <= stat_mem + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a reference model that
// tracks "EX cycles left" for the op in flight.
module tb_pipe_stall_ctrl;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         stallreq_id, stallreq_mem, flush, ex_mc_req;
  logic [W-1:0] ex_mc_len;
  logic [5:0]   stall;
  logic         flush_o, mc_busy, mc_done;
  logic [W-1:0] mc_cyc;
`ifdef STALL_STATS_EN
  logic [31:0]  stat_id, stat_ex, stat_mem;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .flush(flush), .ex_mc_req(ex_mc_req), .ex_mc_len(ex_mc_len),
    .stall(stall), .flush_o(flush_o), .mc_busy(mc_busy), .mc_cyc(mc_cyc),
    .mc_done(mc_done)
`ifdef STALL_STATS_EN
    , .stat_id(stat_id), .stat_ex(stat_ex), .stat_mem(stat_mem)
`endif
  );

  typedef struct {
    logic         id, mem, fl, req;
    logic [W-1:0] len;
    logic [5:0]   e_stall;
    logic         e_flush, e_busy;
    int           e_cyc;
    logic         e_done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic id, input logic mem, input logic fl,
                       input logic req, input logic [W-1:0] len);
    stallreq_id = id; stallreq_mem = mem; flush = fl; ex_mc_req = req; ex_mc_len = len;
  endtask

  task automatic chk_all(input string nm, input logic [5:0] st, input logic fo,
                         input logic bz, input int cy, input logic dn);
    chk({nm, ".stall"},   32'(stall),   32'(st));
    chk({nm, ".flush_o"}, 32'(flush_o), 32'(fo));
    chk({nm, ".busy"},    32'(mc_busy), 32'(bz));
    chk({nm, ".cyc"},     32'(mc_cyc),  32'(cy));
    chk({nm, ".done"},    32'(mc_done), 32'(dn));
  endtask

  // Advance to the next cycle: inputs change 1 ns after the rising edge.
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, '0);
    next_cycle(); next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  // Reference model state: op in flight, EX cycles still to spend, elapsed.
  bit m_active;
  int m_left, m_el;
  int s_id, s_ex, s_mem;

  task automatic model_reset();
    m_active = 0; m_left = 0; m_el = 0; s_id = 0; s_ex = 0; s_mem = 0;
  endtask

  task automatic model_cycle(input bit r, input bit id, input bit mem, input bit fl,
                             input bit req, input int len);
    int  l_eff;
    bit  ex, dn;
    int  cy;
    logic [5:0] st;
    if (!r) begin
      chk_all("rnd_rst", 6'b0, 0, 0, 0, 0);
      model_reset();
      return;
    end
    l_eff = (len == 0) ? 1 : len;
    if (m_active) begin
      ex = (m_left > 1); cy = m_el; dn = (m_left == 1) && !mem && !fl;
    end else begin
      ex = req && (l_eff > 1); cy = 0; dn = req && !fl && (l_eff == 1);
    end
    if (fl)       st = 6'b000000;
    else if (mem) st = 6'b011111;
    else if (ex)  st = 6'b001111;
    else if (id)  st = 6'b000111;
    else          st = 6'b000000;
    chk_all("rnd", st, fl, m_active, cy, dn);
`ifdef STALL_STATS_EN
    chk("rnd.stat_id",  stat_id,  32'(s_id));
    chk("rnd.stat_ex",  stat_ex,  32'(s_ex));
    chk("rnd.stat_mem", stat_mem, 32'(s_mem));
`endif
    if (!fl) begin
      if (mem)      s_mem++;
      else if (ex)  s_ex++;
      else if (id)  s_id++;
    end
    if (fl) begin
      m_active = 0; m_el = 0; m_left = 0;
    end else if (m_active) begin
      if (!mem) begin
        m_left--; m_el++;
        if (m_left == 0) begin m_active = 0; m_el = 0; end
      end
    end else if (req && l_eff > 1) begin
      m_active = 1; m_left = l_eff - 1; m_el = 1;
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, '0);
    #2;
    chk_all("reset", 6'b0, 0, 0, 0, 0);
    // Reset holds outputs quiet even with requests present.
    drive(1, 1, 1, 1, 6'd4);
    #1;
    chk_all("reset_req", 6'b0, 0, 0, 0, 0);
    do_reset();

    //           id mem fl req len   stall     fo bz cy dn
    tbl.push_back('{0, 0, 0, 1, 6'd4, 6'b001111, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 6'd4, 6'b001111, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 1, 6'd4, 6'b001111, 0, 1, 2, 0});
    tbl.push_back('{0, 0, 0, 1, 6'd4, 6'b000000, 0, 1, 3, 1});
    tbl.push_back('{0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 6'd1, 6'b000000, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 6'd0, 6'b000000, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 6'd3, 6'b001111, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 6'd0, 6'b001111, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 6'd0, 6'b000111, 0, 1, 2, 1});
    tbl.push_back('{1, 0, 0, 0, 6'd0, 6'b000111, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 6'd0, 6'b011111, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 1, 6'd5, 6'b000000, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      drive(tbl[i].id, tbl[i].mem, tbl[i].fl, tbl[i].req, tbl[i].len);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_flush,
              tbl[i].e_busy, tbl[i].e_cyc, tbl[i].e_done);
      next_cycle();
    end

    // Reset mid-op: len=10, asserted in the 4th EX cycle.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 0, 1, 6'd10);
      next_cycle();
    end
    @(negedge clk);
    chk_all("pre_rst", 6'b001111, 0, 1, 3, 0);
    rst = 1'b0;
    #1;
    chk_all("mid_rst", 6'b0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b1;
    drive(0, 0, 0, 0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk_all("post_rst", 6'b0, 0, 0, 0, 0);
      next_cycle();
    end

    // len=5 with MEM wait on cycles 3..5: EX frozen, done on cycle 8.
    begin
      int exp_cyc[8]    = '{0, 1, 2, 2, 2, 2, 3, 4};
      logic [5:0] es[8] = '{6'h0f, 6'h0f, 6'h1f, 6'h1f, 6'h1f, 6'h0f, 6'h0f, 6'h00};
      for (int c = 1; c <= 8; c++) begin
        drive(0, (c >= 3 && c <= 5), 0, (c == 1), 6'd5);
        @(negedge clk);
        chk_all($sformatf("memfrz%0d", c), es[c-1], 0, (c > 1), exp_cyc[c-1], (c == 8));
        next_cycle();
      end
      drive(0, 0, 0, 0, '0);
      @(negedge clk);
      chk_all("memfrz_end", 6'b0, 0, 0, 0, 0);
      next_cycle();
    end

    // Flush after three EX-held cycles of a len=6 op.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 0, (c == 1), 6'd6);
      @(negedge clk);
      chk_all($sformatf("fl_pre%0d", c), 6'b001111, 0, (c > 1), c - 1, 0);
      next_cycle();
    end
    drive(1, 0, 1, 0, '0);
    @(negedge clk);
    chk_all("flush", 6'b0, 1, 1, 3, 0);
    next_cycle();
    drive(0, 0, 0, 0, '0);
    @(negedge clk);
    chk_all("post_flush", 6'b0, 0, 0, 0, 0);
`ifdef STALL_STATS_EN
    chk("flush.stat_ex",  stat_ex,  32'd3);
    chk("flush.stat_id",  stat_id,  32'd0);
    chk("flush.stat_mem", stat_mem, 32'd0);
`endif
    next_cycle();

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit r, id, mem, fl, req;
      int len;
      r   = ($urandom_range(0, 199) != 0);
      id  = ($urandom_range(0, 4) == 0);
      mem = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 31) == 0);
      req = ($urandom_range(0, 2) == 0);
      len = $urandom_range(0, 12);
      rst = r;
      drive(id, mem, fl, req, W'(len));
      @(negedge clk);
      model_cycle(r, id, mem, fl, req, len);
      next_cycle();
    end
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
